shift_alu_arbiter: RTL and testbench
====================================

// Module: shift_alu_arbiter
// PURPOSE
//   Shares one 16-bit shift/rotate ALU (SLL, RL, SRL, RR) between NUM_REQ requesters.
//   Round-robin arbitration, valid/ready on both sides, one registered result slot.
//   Instantiates the alu block internally. Sits between client engines and the shared shifter.
// PARAMETERS
//   NUM_REQ  4   number of requesters (1..16)
//   IDW      2   width of rsp_id; must be >= max(1, $clog2(NUM_REQ))
// PORTS
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous, active-high reset
//   req_valid   in   NUM_REQ      per-requester request valid
//   req_ready   out  NUM_REQ      per-requester accept strobe; one-hot or zero
//   req_choice  in   2*NUM_REQ    op per requester: 00 SLL, 01 RL, 10 SRL, 11 RR; slice k = [2k+1:2k]
//   req_data    in   16*NUM_REQ   operand per requester; slice k = [16k+15:16k]
//   req_shift   in   4*NUM_REQ    shift amount 0..15 per requester; slice k = [4k+3:4k]
//   rsp_valid   out  1            result slot holds a valid result
//   rsp_ready   in   1            consumer accepts the result
//   rsp_id      out  IDW          index of the requester that owns rsp_data
//   rsp_data    out  16           ALU result
//   busy_cycles out  16           saturating count of cycles with rsp_valid=1 and rsp_ready=0
// BEHAVIOUR
//   Reset: rsp_valid=0, rsp_id=0, rsp_data=0, busy_cycles=0, RR pointer=0 (requester 0 highest priority).
//   Slot free when rsp_valid=0 OR (rsp_valid=1 AND rsp_ready=1). Drain and accept happen in the same cycle.
//   Grant, combinational:
//     - Free slot: pick the first asserted req_valid, scanning from pointer upward and wrapping at NUM_REQ.
//     - Assert req_ready only for the selected requester.
//     - No free slot or no valid request: req_ready = 0.
//   Handshake: a transfer occurs when req_valid[k] and req_ready[k] are both 1. req_ready[k] never rises
//     without req_valid[k]. Requesters hold their payload until they are accepted.
//   Accept at edge N:
//     - rsp_data = alu(choice, data, shift) of the granted slice; rsp_id = k; rsp_valid = 1 visible in cycle N+1.
//     - Latency 1 cycle. Throughput 1 op/cycle while rsp_ready=1.
//   Pointer after a grant to k: (k+1) mod NUM_REQ. Unchanged when there is no grant.
//   Slot FSM:
//     - EMPTY -> FULL on accept.
//     - FULL -> FULL on drain+accept, with new data loaded.
//     - FULL -> EMPTY on drain with no accept.
//     - FULL with rsp_ready=0: hold. rsp_data and rsp_id stay stable, no grants, busy_cycles increments
//       and saturates at 0xFFFF.
//   ALU semantics:
//     - Shifts fill with 0. Rotates are modulo 16. shift 0 passes the operand through.
//     - SLL/RL move bits toward the MSB; SRL/RR move bits toward the LSB.
//   Reset asserted mid-stall or mid-stream: the held result is dropped. Next cycle has rsp_valid=0 and
//     pointer=0. No req_ready while rst=1.
//   NUM_REQ=1: degenerates to a 1-deep pipeline register with rsp_id=0.
// TESTING
//   1. Hold rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0, busy_cycles=0;
//      first cycle after reset grants req 0.
//   2. req0 SLL data=0x8001 shift=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0002.
//      Repeat for RL -> 0x0003, SRL -> 0x4000, RR -> 0xC000.
//   3. All 4 req_valid held, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one
//      cycle later; 1 result/cycle.
//   4. req0 accepted, then rsp_ready=0 for 3 cycles -> rsp_data/rsp_id stable, all req_ready=0,
//      busy_cycles=3. Raising rsp_ready drains the slot and grants the next requester in the same cycle.
//   5. rst pulsed while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 the next cycle. With req1 and req3 valid,
//      req1 is granted first (pointer=0).
//   6. Shift amount edges: RR data=0x1234 shift=0 -> 0x1234; SRL 0xFFFF shift=15 -> 0x0001;
//      RL 0x0001 shift=15 -> 0x8000.
//      Random run versus a reference model with random rsp_ready: no result lost, duplicated or reordered.

Source files
------------

// File: rtl/shift_alu_arbiter.sv
// -----------------------------------------------------------------------------
// shift_alu_arbiter
//   Shares one 16-bit shift/rotate ALU between NUM_REQ requesters. A round-robin
//   arbiter picks one requester per cycle while the single result slot is free
//   (empty, or being drained this cycle). The ALU result is registered into that
//   slot and presented with a valid/ready handshake towards the consumer.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    per-requester request valid              [NUM_REQ]
//   req_ready    per-requester accept strobe, one-hot/zero [NUM_REQ]
//   req_choice   op per requester (00 SLL, 01 RL, 10 SRL, 11 RR), slice k = [2k+1:2k]
//   req_data     operand per requester, slice k = [16k+15:16k]
//   req_shift    shift amount per requester, slice k = [4k+3:4k]
//   rsp_valid    result slot holds a valid result
//   rsp_ready    consumer accepts the result
//   rsp_id       index of the requester owning rsp_data
//   rsp_data     ALU result
//   busy_cycles  saturating count of cycles with rsp_valid=1 and rsp_ready=0
//
// Also contains shift_alu, the shared combinational shifter.
// -----------------------------------------------------------------------------

// shift_alu: op 00 SLL, 01 RL (rotate toward MSB), 10 SRL, 11 RR (rotate toward LSB).
// Ports: op (2), a (16 operand), sh (4 amount), y (16 result).
module shift_alu (
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [3:0]  sh,
  output logic [15:0] y
);
  logic [31:0] dbl_l;
  logic [31:0] dbl_r;

  // Rotates are taken from a doubled operand so that sh=0 needs no special case.
  always_comb begin
    dbl_l = {a, a} << sh;
    dbl_r = {a, a} >> sh;
    y     = a;
    case (op)
      2'b00:   y = a << sh;
      2'b01:   y = dbl_l[31:16];
      2'b10:   y = a >> sh;
      default: y = dbl_r[15:0];
    endcase
  end
endmodule

module shift_alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_choice,
  input  logic [16*NUM_REQ-1:0]  req_data,
  input  logic [4*NUM_REQ-1:0]   req_shift,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            rsp_data,
  output logic [15:0]            busy_cycles
);
  localparam int DATA_W = 16;
  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_EMPTY, S_FULL} slot_e;

  slot_e             state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]       busy_q, busy_d;

  logic              slot_free;
  logic              gnt_found;
  logic [PW-1:0]     gnt_idx;
  logic              grant;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        sel_sh;
  logic [DATA_W-1:0] alu_y;

  // ---- Stage 0: round-robin arbitration, payload select, shared ALU ----

  assign rsp_valid = (state_q == S_FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // Two passes: first requesters at or above the pointer, then the wrapped part.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[k] && (k >= int'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[k] && (k < int'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
  end

  assign grant = !rst && slot_free && gnt_found;

  always_comb begin
    sel_op    = '0;
    sel_data  = '0;
    sel_sh    = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_op   = req_choice[2*k +: 2];
        sel_data = req_data[16*k +: 16];
        sel_sh   = req_shift[4*k +: 4];
      end
      req_ready[k] = grant && (gnt_idx == PW'(k));
    end
  end

  shift_alu u_alu (
    .op (sel_op),
    .a  (sel_data),
    .sh (sel_sh),
    .y  (alu_y)
  );

  // ---- Stage 1: result slot FSM, pointer and stall counter ----

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    busy_d     = busy_q;

    if (grant) begin
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    case (state_q)
      S_EMPTY: begin
        if (grant) begin
          state_d    = S_FULL;
          rsp_id_d   = IDW'(gnt_idx);
          rsp_data_d = alu_y;
        end
      end
      default: begin
        if (rsp_ready) begin
          // Drain and refill in the same cycle keeps throughput at 1 op/cycle.
          if (grant) begin
            rsp_id_d   = IDW'(gnt_idx);
            rsp_data_d = alu_y;
          end else begin
            state_d = S_EMPTY;
          end
        end else if (busy_q != 16'hFFFF) begin
          busy_d = busy_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      busy_q     <= busy_d;
    end
  end

  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_shift_alu_arbiter.sv
module tb_shift_alu_arbiter;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_choice;
  logic [16*NREQ-1:0] req_data;
  logic [4*NREQ-1:0] req_shift;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_data;
  logic [15:0]       busy_cycles;

  shift_alu_arbiter #(.NUM_REQ(NREQ), .IDW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_choice  (req_choice),
    .req_data    (req_data),
    .req_shift   (req_shift),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy_cycles (busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side stimulus state
  logic [1:0]  ch [NREQ];
  logic [15:0] dt [NREQ];
  logic [3:0]  sh [NREQ];
  logic        vl [NREQ];

  // Reference model: a 1-deep result slot modelled as a queue of outstanding results
  int          q_id   [$];
  logic [15:0] q_data [$];
  int          m_ptr;
  int          m_busy;

  int          n_checks;
  int          n_err;
  logic [NREQ-1:0] last_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] d, input int s);
    int x;
    int r;
    x = int'(d);
    case (op)
      2'd0:    r = x << s;
      2'd1:    r = (x << s) | (x >> (16 - s));
      2'd2:    r = x >> s;
      default: r = (x >> s) | (x << (16 - s));
    endcase
    return r[15:0];
  endfunction

  function automatic int model_grant();
    int k;
    if (rst) return -1;
    if (q_id.size() != 0 && !rsp_ready) return -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (vl[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]          = vl[k];
      req_choice[2*k +: 2]  = ch[k];
      req_data[16*k +: 16]  = dt[k];
      req_shift[4*k +: 4]   = sh[k];
    end
  endtask

  // One clock cycle: apply inputs, compare against the model mid-cycle,
  // advance the model at the edge, return 1 time unit after the edge.
  task automatic cycle();
    int g;
    logic [31:0] exp_rr;
    drive();
    #1;
    g = model_grant();
    exp_rr = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("req_ready", {28'd0, req_ready}, exp_rr);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (q_id.size() != 0)});
    if (q_id.size() != 0) begin
      chk("rsp_id", {30'd0, rsp_id}, q_id[0]);
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, q_data[0]});
    end
    chk("busy_cycles", {16'd0, busy_cycles}, m_busy);
    last_rr = req_ready;
    @(posedge clk);
    if (rst) begin
      q_id.delete();
      q_data.delete();
      m_ptr  = 0;
      m_busy = 0;
    end else begin
      if (q_id.size() != 0) begin
        if (rsp_ready) begin
          void'(q_id.pop_front());
          void'(q_data.pop_front());
        end else if (m_busy < 16'hFFFF) begin
          m_busy++;
        end
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_data.push_back(ref_alu(ch[g], dt[g], int'(sh[g])));
        m_ptr = (g + 1) % NREQ;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  logic [1:0]  t_op  [4];
  logic [15:0] t_exp [4];
  logic [1:0]  e_op  [3];
  logic [15:0] e_dat [3];
  logic [3:0]  e_sh  [3];
  logic [15:0] e_exp [3];

  initial begin
    n_checks = 0;
    n_err    = 0;
    m_ptr    = 0;
    m_busy   = 0;
    last_rr  = '0;
    for (int k = 0; k < NREQ; k++) begin
      ch[k] = 2'd0; dt[k] = 16'd0; sh[k] = 4'd0; vl[k] = 1'b1;
    end

    // 1. Reset held two cycles with all requests valid
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    cycle();
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("reset_busy", {16'd0, busy_cycles}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("first_grant", {28'd0, last_rr}, 32'd1);

    // 2. Each operation on 0x8001 shifted by 1
    t_op[0] = 2'd0; t_exp[0] = 16'h0002;
    t_op[1] = 2'd1; t_exp[1] = 16'h0003;
    t_op[2] = 2'd2; t_exp[2] = 16'h4000;
    t_op[3] = 2'd3; t_exp[3] = 16'hC000;
    for (int k = 1; k < NREQ; k++) vl[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vl[0] = 1'b1; ch[0] = t_op[i]; dt[0] = 16'h8001; sh[0] = 4'd1;
      cycle();
      chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("op_rsp_id", {30'd0, rsp_id}, 32'd0);
      chk("op_rsp_data", {16'd0, rsp_data}, {16'd0, t_exp[i]});
    end
    vl[0] = 1'b0;
    cycle();

    // 3. Round robin across all four requesters from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      vl[k] = 1'b1; ch[k] = 2'd0; sh[k] = 4'd0; dt[k] = 16'h1111 * 16'(k + 1);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_grant", {28'd0, last_rr}, 32'd1 << (i % 4));
      chk("rr_rsp_id", {30'd0, rsp_id}, i % 4);
      chk("rr_rsp_data", {16'd0, rsp_data}, {16'd0, dt[i % 4]});
    end

    // 4. Stall for three cycles, then drain with a same-cycle grant
    for (int k = 0; k < NREQ; k++) vl[k] = 1'b0;
    vl[0] = 1'b1; dt[0] = 16'hABCD; ch[0] = 2'd2; sh[0] = 4'd0;
    cycle();
    vl[0] = 1'b0; vl[2] = 1'b1; dt[2] = 16'h0F0F; ch[2] = 2'd1; sh[2] = 4'd4;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_no_grant", {28'd0, last_rr}, 32'd0);
      chk("stall_rsp_data", {16'd0, rsp_data}, 32'hABCD);
      chk("stall_rsp_id", {30'd0, rsp_id}, 32'd0);
    end
    chk("stall_busy", {16'd0, busy_cycles}, 32'd3);
    rsp_ready = 1'b1;
    cycle();
    chk("drain_grant", {28'd0, last_rr}, 32'h4);
    chk("drain_rsp_id", {30'd0, rsp_id}, 32'd2);
    chk("drain_rsp_data", {16'd0, rsp_data}, 32'hF0F0);

    // 5. Reset during a stall drops the held result and restarts the pointer
    vl[2] = 1'b0;
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_no_grant", {28'd0, last_rr}, 32'd0);
    chk("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    vl[1] = 1'b1; vl[3] = 1'b1;
    cycle();
    chk("post_rst_grant", {28'd0, last_rr}, 32'h2);
    chk("post_rst_busy", {16'd0, busy_cycles}, 32'd0);
    for (int k = 0; k < NREQ; k++) vl[k] = 1'b0;

    // 6. Shift amount edges
    e_op[0] = 2'd3; e_dat[0] = 16'h1234; e_sh[0] = 4'd0;  e_exp[0] = 16'h1234;
    e_op[1] = 2'd2; e_dat[1] = 16'hFFFF; e_sh[1] = 4'd15; e_exp[1] = 16'h0001;
    e_op[2] = 2'd1; e_dat[2] = 16'h0001; e_sh[2] = 4'd15; e_exp[2] = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      vl[0] = 1'b1; ch[0] = e_op[i]; dt[0] = e_dat[i]; sh[0] = e_sh[i];
      cycle();
      chk("edge_rsp_data", {16'd0, rsp_data}, {16'd0, e_exp[i]});
    end
    vl[0] = 1'b0;
    cycle();

    // Random run: requesters hold payload until accepted, random back-pressure and resets
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (last_rr[k]) vl[k] = 1'b0;
        if (!vl[k] && ($urandom_range(1, 0) == 1)) begin
          vl[k] = 1'b1;
          ch[k] = 2'($urandom_range(3, 0));
          dt[k] = 16'($urandom);
          sh[k] = 4'($urandom_range(15, 0));
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(63, 0) == 0);
      cycle();
    end

    // Drain whatever is left
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) vl[k] = 1'b0;
    cycle();
    cycle();
    chk("final_empty", {31'd0, rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
